seq_alu: RTL and testbench

//  Parametrised, registered successor of the team's 16-bit combinational ALU. Accepts one

---
 rtl/alu_pkg.sv | 22 ++
 rtl/shift_add_mul.sv | 48 ++++
 rtl/seq_alu.sv | 144 ++++++++++++++
 tb/tb_seq_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU and its bench.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_NEG = 3'b000,
      OP_INC = 3'b001,
      OP_ADC = 3'b010,
      OP_AHS = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_CAT = 3'b110,
      OP_MUL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per step, multiplier consumed LSB-first.
module shift_add_mul #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 last
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

   // prod is the post-step value so the caller can register it on the final step edge
   assign prod = acc_nxt;
   assign last = step && (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake and a multi-cycle shift-add multiply.
//  state  | meaning
//  S_IDLE | waiting for start; operands captured on the accepting edge
//  S_EXEC | single-cycle op evaluated from captured operands, result registered
//  S_MUL  | one shift-add step per cycle, WIDTH steps, result registered on the last
//  S_DONE | done pulse, result valid; start ignored
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       opc,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic             inc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] w,
   output logic             zer,
   output logic             neg,
   output logic             cout
);

   localparam int HALF = WIDTH / 2;

   state_e             state_q, state_d;
   alu_op_e            opc_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               inc_q;
   logic               accept;
   logic               mul_load, mul_last;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   b_half;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_w;
   logic               alu_c;
   logic [WIDTH-1:0]   w_q;
   logic               cout_q;

   assign accept   = (state_q == S_IDLE) && start;
   assign mul_load = accept && (alu_op_e'(opc) == OP_MUL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (alu_op_e'(opc) == OP_MUL) ? S_MUL : S_EXEC;
         S_EXEC:  state_d = S_DONE;
         S_MUL:   if (mul_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_EXEC) || (state_q == S_MUL);
      done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opc_q <= OP_NEG;
         a_q   <= '0;
         b_q   <= '0;
         inc_q <= 1'b0;
      end else if (accept) begin
         opc_q <= alu_op_e'(opc);
         a_q   <= ina;
         b_q   <= inb;
         inc_q <= inc;
      end
   end

   shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk  (clk),
      .rst  (rst),
      .load (mul_load),
      .step (state_q == S_MUL),
      .a    (ina),
      .b    (inb),
      .prod (mul_prod),
      .last (mul_last)
   );

   // arithmetic shift floors toward -inf, so odd negative B rounds down
   assign b_half = WIDTH'($signed(b_q) >>> 1);

   always_comb begin
      alu_w = '0;
      alu_c = 1'b0;
      sum   = '0;
      case (opc_q)
         OP_NEG: alu_w = ~a_q + WIDTH'(1);
         OP_INC: begin
            sum   = {1'b0, a_q} + (WIDTH+1)'(1);
            alu_w = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
         end
         OP_ADC: begin
            sum   = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(inc_q);
            alu_w = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
         end
         OP_AHS: begin
            sum   = {1'b0, a_q} + {1'b0, b_half};
            alu_w = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
         end
         OP_AND: alu_w = a_q & b_q;
         OP_OR:  alu_w = a_q | b_q;
         OP_CAT: alu_w = {a_q[HALF-1:0], b_q[HALF-1:0]};
         default: begin
            alu_w = '0;
            alu_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q    <= '0;
         cout_q <= 1'b0;
      end else if (state_q == S_EXEC) begin
         w_q    <= alu_w;
         cout_q <= alu_c;
      end else if (mul_last) begin
         w_q    <= mul_prod[WIDTH-1:0];
         cout_q <= |mul_prod[2*WIDTH-1:WIDTH];
      end
   end

   assign w    = w_q;
   assign cout = cout_q;
   assign zer  = (w_q == '0);
   assign neg  = w_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16 and WIDTH=8 with hand-computed expectations.
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;

   logic        start16, inc16;
   logic [2:0]  opc16;
   logic [15:0] ina16, inb16;
   logic        busy16, done16, zer16, neg16, cout16;
   logic [15:0] w16;

   logic        start8, inc8;
   logic [2:0]  opc8;
   logic [7:0]  ina8, inb8;
   logic        busy8, done8, zer8, neg8, cout8;
   logic [7:0]  w8;

   int ncmp  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .opc(opc16), .ina(ina16), .inb(inb16),
      .inc(inc16), .busy(busy16), .done(done16), .w(w16), .zer(zer16), .neg(neg16),
      .cout(cout16)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .opc(opc8), .ina(ina8), .inb(inb8),
      .inc(inc8), .busy(busy8), .done(done8), .w(w8), .zer(zer8), .neg(neg8),
      .cout(cout8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sm, input logic s, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic c);
      if (sm) begin
         start8 = s; opc8 = op; ina8 = a[7:0]; inb8 = b[7:0]; inc8 = c;
      end else begin
         start16 = s; opc16 = op; ina16 = a; inb16 = b; inc16 = c;
      end
   endtask

   // Called at a falling edge with the selected DUT idle; returns at the falling edge after done.
   task automatic do_op(input bit sm, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input int exp_lat,
                        input logic [15:0] exp_w, input logic exp_c, input bit poke,
                        input bit hold, input string tag);
      int          lat;
      logic [15:0] ow, ew;
      logic        ez, en;
      drive(sm, 1'b1, op, a, b, c);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            drive(sm, 1'b0, op, 16'($urandom), 16'($urandom), 1'($urandom));
            chk({tag, " busy"}, sm ? busy8 : busy16, 1);
         end
         if ((sm ? done8 : done16) === 1'b1) begin
            lat = i;
            break;
         end
         if (poke) drive(sm, 1'b1, OP_AND, 16'($urandom), 16'($urandom), 1'b0);
      end
      if (hold) drive(sm, 1'b1, OP_OR, 16'hFFFF, 16'hFFFF, 1'b0);
      else      drive(sm, 1'b0, OP_OR, 16'h0, 16'h0, 1'b0);
      ew = sm ? {8'h00, exp_w[7:0]} : exp_w;
      ez = (ew == 16'h0);
      en = sm ? exp_w[7] : exp_w[15];
      ow = sm ? {8'h00, w8} : w16;
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " w"},    ow, ew);
      chk({tag, " zer"},  sm ? zer8 : zer16, ez);
      chk({tag, " neg"},  sm ? neg8 : neg16, en);
      chk({tag, " cout"}, sm ? cout8 : cout16, exp_c);
      chk({tag, " busy in done"}, sm ? busy8 : busy16, 0);
      @(negedge clk);
      chk({tag, " done one cycle"}, sm ? done8 : done16, 0);
      chk({tag, " idle after done"}, sm ? busy8 : busy16, 0);
      chk({tag, " w held"}, sm ? {8'h00, w8} : w16, ew);
   endtask

   initial begin
      int seen_done;
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      #1;
      chk("reset busy", busy16, 0);
      chk("reset done", done16, 0);
      chk("reset w",    w16, 16'h0);
      chk("reset zer",  zer16, 1);
      chk("reset neg",  neg16, 0);
      chk("reset cout", cout16, 0);
      @(negedge clk);
      rst = 1'b0;

      do_op(0, OP_ADC, 16'hFFFF, 16'h0001, 1'b1, 2,  16'h0001, 1'b1, 0, 0, "adc wrap");
      do_op(0, OP_NEG, 16'h0000, 16'h1234, 1'b0, 2,  16'h0000, 1'b0, 0, 0, "neg zero");
      do_op(0, OP_NEG, 16'h0001, 16'h0000, 1'b0, 2,  16'hFFFF, 1'b0, 0, 0, "neg one");
      do_op(0, OP_AHS, 16'h0010, 16'hFFFB, 1'b0, 2,  16'h000D, 1'b1, 0, 0, "ahs neg b");
      do_op(0, OP_CAT, 16'h12AB, 16'h34CD, 1'b0, 2,  16'hABCD, 1'b0, 0, 0, "cat");
      do_op(0, OP_INC, 16'hFFFF, 16'h0000, 1'b0, 2,  16'h0000, 1'b1, 0, 0, "inc wrap");
      do_op(0, OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 2,  16'h3030, 1'b0, 0, 0, "and");
      do_op(0, OP_OR,  16'hF0F0, 16'h0F01, 1'b0, 2,  16'hFFF1, 1'b0, 0, 0, "or");
      do_op(0, OP_MUL, 16'h0100, 16'h0100, 1'b0, 17, 16'h0000, 1'b1, 0, 0, "mul overflow");
      do_op(0, OP_MUL, 16'h0003, 16'h0005, 1'b0, 17, 16'h000F, 1'b0, 1, 0, "mul busy pokes");
      do_op(0, OP_MUL, 16'h1234, 16'h0000, 1'b0, 17, 16'h0000, 1'b0, 0, 0, "mul by zero");
      do_op(0, OP_ADC, 16'h7FFF, 16'h0000, 1'b0, 2,  16'h7FFF, 1'b0, 0, 0, "adc no carry");

      // abort a multiply partway through
      drive(0, 1'b1, OP_MUL, 16'h0005, 16'h0007, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, OP_MUL, 16'h0, 16'h0, 1'b0);
      repeat (4) @(negedge clk);
      chk("pre-abort busy", busy16, 1);
      rst = 1'b1;
      #1;
      chk("abort busy", busy16, 0);
      chk("abort done", done16, 0);
      chk("abort w",    w16, 16'h0);
      chk("abort zer",  zer16, 1);
      chk("abort cout", cout16, 0);
      seen_done = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == 1) rst = 1'b0;
         if (done16 === 1'b1) seen_done++;
      end
      chk("abort no done", seen_done, 0);
      chk("abort w stays", w16, 16'h0);

      do_op(1, OP_MUL, 16'h00FF, 16'h00FF, 1'b0, 9, 16'h0001, 1'b1, 0, 1, "w8 mul ff");
      do_op(1, OP_ADC, 16'h000F, 16'h0001, 1'b0, 2, 16'h0010, 1'b0, 0, 0, "w8 back2back adc");
      do_op(1, OP_CAT, 16'h0012, 16'h0034, 1'b0, 2, 16'h0024, 1'b0, 0, 0, "w8 cat");
      do_op(1, OP_INC, 16'h00FF, 16'h0000, 1'b0, 2, 16'h0000, 1'b1, 0, 0, "w8 inc wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
